ccd_readout_sequencer: RTL and testbench

//  Frame-level controller that sequences signal_generator through one CCD exposure: integrate, then per row a

---
 rtl/ccd_pkg.sv | 27 ++
 rtl/ccd_seq_timer.sv | 27 ++
 rtl/ccd_readout_sequencer.sv | 161 ++++++++++++++++
 tb/tb_ccd_readout_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ccd_pkg.sv
// Shared definitions for the CCD readout sequencer: sel mode codes, FSM state encoding
// and the state-to-sel decode.
package ccd_pkg;

    localparam logic [3:0] SEL_IDLE  = 4'b0000;
    localparam logic [3:0] SEL_VXFER = 4'b1010;
    localparam logic [3:0] SEL_HREAD = 4'b0101;
    localparam logic [3:0] SEL_INT   = 4'b0000;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_INT   = 3'd1;
    localparam state_t ST_VXFER = 3'd2;
    localparam state_t ST_HREAD = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    function automatic logic [3:0] sel_for_state(input state_t st);
        case (st)
            ST_INT:   return SEL_INT;
            ST_VXFER: return SEL_VXFER;
            ST_HREAD: return SEL_HREAD;
            default:  return SEL_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/ccd_seq_timer.sv
// Loadable down-counter with zero flag; times integration, vertical-transfer and pixel periods.
module ccd_seq_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    // A load always wins; decrementing stops at zero so a stalled period can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ccd_readout_sequencer.sv
// Frame controller: integrate, then per row a vertical transfer and serial pixel readout.
// Defining CCD_SEQ_ABORT_EN adds an abort input that returns a running frame to IDLE.
module ccd_readout_sequencer
    import ccd_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int INT_W      = 16,
    parameter int VSHIFT_CYC = 4,
    parameter int PIX_CYC    = 4,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [INT_W-1:0] int_time,
`ifdef CCD_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [3:0]       sel,
    output logic             busy,
    output logic             done,
    output logic             sample,
    output logic [RW-1:0]    row_idx,
    output logic [CW-1:0]    col_idx
);

    localparam int TW_V  = $clog2(VSHIFT_CYC + 1);
    localparam int TW_P  = $clog2(PIX_CYC + 1);
    localparam int TW_VP = (TW_V > TW_P) ? TW_V : TW_P;
    localparam int TW    = (INT_W > TW_VP) ? INT_W : TW_VP;

    localparam logic [TW-1:0] V_LOAD   = TW'(VSHIFT_CYC - 1);
    localparam logic [TW-1:0] P_LOAD   = TW'(PIX_CYC - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    state_t          state, state_n;
    logic [RW-1:0]   row_n;
    logic [CW-1:0]   col_n;
    logic            tmr_load, tmr_dec, tmr_zero, abort_hit;
    logic [TW-1:0]   tmr_val, tmr_count;

`ifdef CCD_SEQ_ABORT_EN
    assign abort_hit = abort && (state != ST_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    ccd_seq_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    // Each timed state is loaded with its length minus one and exits on the cycle the timer reads zero.
    always_comb begin
        state_n  = state;
        row_n    = row_idx;
        col_n    = col_idx;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    tmr_load = 1'b1;
                    if (int_time != '0) begin
                        state_n = ST_INT;
                        tmr_val = TW'(int_time - INT_W'(1));
                    end else begin
                        state_n = ST_VXFER;
                        tmr_val = V_LOAD;
                    end
                end
            end
            ST_INT: begin
                if (tmr_zero) begin
                    state_n  = ST_VXFER;
                    tmr_load = 1'b1;
                    tmr_val  = V_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_VXFER: begin
                if (tmr_zero) begin
                    state_n  = ST_HREAD;
                    tmr_load = 1'b1;
                    tmr_val  = P_LOAD;
                    col_n    = '0;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_HREAD: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if (col_idx != COL_LAST) begin
                    col_n    = col_idx + CW'(1);
                    tmr_load = 1'b1;
                    tmr_val  = P_LOAD;
                end else begin
                    col_n = '0;
                    if (row_idx == ROW_LAST) begin
                        state_n = ST_DONE;
                    end else begin
                        row_n    = row_idx + RW'(1);
                        state_n  = ST_VXFER;
                        tmr_load = 1'b1;
                        tmr_val  = V_LOAD;
                    end
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
                row_n   = '0;
                col_n   = '0;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (abort_hit) begin
            state_n  = ST_IDLE;
            row_n    = '0;
            col_n    = '0;
            tmr_load = 1'b1;
            tmr_val  = '0;
            tmr_dec  = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    // The sample strobe fires when the pixel timer is about to reach zero without a reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            sel     <= SEL_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sample  <= 1'b0;
            row_idx <= '0;
            col_idx <= '0;
        end else begin
            state   <= state_n;
            sel     <= sel_for_state(state_n);
            busy    <= (state_n != ST_IDLE);
            done    <= (state_n == ST_DONE);
            sample  <= (state_n == ST_HREAD) && !tmr_load && (tmr_count == TW'(1));
            row_idx <= row_n;
            col_idx <= col_n;
        end
    end

endmodule

// File: tb/tb_ccd_readout_sequencer.sv
// Directed bench for ccd_readout_sequencer with a per-cycle model of the frame timeline.
module tb_ccd_readout_sequencer;
    import ccd_pkg::*;

    localparam int ROW_PERIOD = 4 + 8 * 4;
    localparam int READ_CYC   = 8 * ROW_PERIOD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] int_time;
    logic        abort;
    logic [3:0]  sel;
    logic        busy;
    logic        done;
    logic        sample;
    logic [2:0]  row_idx;
    logic [2:0]  col_idx;

    int checks = 0;
    int errors = 0;
    int nSamples;

    always #5 clk = ~clk;

    ccd_readout_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .int_time (int_time),
`ifdef CCD_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .sel      (sel),
        .busy     (busy),
        .done     (done),
        .sample   (sample),
        .row_idx  (row_idx),
        .col_idx  (col_idx)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs for cycle k after the start cycle of a frame with integration time it.
    task automatic checkOutput(input int k, input int it);
        int total, t, p, q;
        logic [3:0] eSel;
        logic eBusy, eDone, eSample;
        total   = 1 + it + READ_CYC;
        eSel    = 4'b0000;
        eBusy   = 1'b1;
        eDone   = 1'b0;
        eSample = 1'b0;
        t = 0;
        p = 0;
        q = 0;
        if (k == total) begin
            eDone = 1'b1;
        end else if (k > total) begin
            eBusy = 1'b0;
        end else if (k > it) begin
            t = k - 1 - it;
            p = t % ROW_PERIOD;
            if (p < 4) begin
                eSel = 4'b1010;
            end else begin
                eSel    = 4'b0101;
                q       = p - 4;
                eSample = ((q % 4) == 3);
            end
        end
        checkVal($sformatf("sel@%0d", k), 32'(sel), 32'(eSel));
        checkVal($sformatf("busy@%0d", k), 32'(busy), 32'(eBusy));
        checkVal($sformatf("done@%0d", k), 32'(done), 32'(eDone));
        checkVal($sformatf("sample@%0d", k), 32'(sample), 32'(eSample));
        if (eSample) begin
            checkVal($sformatf("row@%0d", k), 32'(row_idx), t / ROW_PERIOD);
            checkVal($sformatf("col@%0d", k), 32'(col_idx), q / 4);
        end
        if (sample === 1'b1) nSamples++;
    endtask

    // Starts a frame and follows it cycle by cycle; stopAt>0 leaves the loop early at that cycle.
    task automatic applyStimulus(input int it, input bit pokeStart, input int stopAt);
        int total, last;
        total    = 1 + it + READ_CYC;
        last     = (stopAt > 0) ? stopAt : total + 1;
        nSamples = 0;
        @(negedge clk);
        start    = 1'b1;
        int_time = 16'(it);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            checkOutput(k, it);
            start = pokeStart && (k == 100 || k == total);
            if (pokeStart && k == 100) int_time = 16'd3;
        end
        start = 1'b0;
        if (stopAt == 0) checkVal($sformatf("sampleCount it=%0d", it), nSamples, 64);
    endtask

    task automatic checkIdle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkVal({tag, " sel"}, 32'(sel), 0);
            checkVal({tag, " busy"}, 32'(busy), 0);
            checkVal({tag, " done"}, 32'(done), 0);
            checkVal({tag, " sample"}, 32'(sample), 0);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkVal({tag, " sel"}, 32'(sel), 0);
        checkVal({tag, " busy"}, 32'(busy), 0);
        checkVal({tag, " done"}, 32'(done), 0);
        checkVal({tag, " sample"}, 32'(sample), 0);
        checkVal({tag, " row"}, 32'(row_idx), 0);
        checkVal({tag, " col"}, 32'(col_idx), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        int_time = 16'd0;
        abort    = 1'b0;
        repeat (2) @(negedge clk);
        checkResetValues("inReset");
        rst_n = 1'b1;
        checkIdle(50, "postReset");

        $display("[TB] frame int_time=10");
        applyStimulus(10, 1'b0, 0);
        checkIdle(3, "afterFrame10");

        $display("[TB] frame int_time=0");
        applyStimulus(0, 1'b0, 0);
        checkIdle(3, "afterFrame0");

        $display("[TB] frame with stray start pulses");
        applyStimulus(10, 1'b1, 0);
        checkIdle(5, "afterStrayStart");

        $display("[TB] reset at row 3");
        applyStimulus(5, 1'b0, 6 + 3 * ROW_PERIOD + 10);
        rst_n = 1'b0;
        #1;
        checkResetValues("midFrameReset");
        @(negedge clk);
        rst_n = 1'b1;
        checkIdle(10, "afterMidReset");
        applyStimulus(7, 1'b0, 0);
        checkIdle(3, "afterCleanFrame");

`ifdef CCD_SEQ_ABORT_EN
        $display("[TB] abort at cycle 50");
        applyStimulus(10, 1'b0, 50);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkResetValues("abort");
        checkIdle(20, "afterAbort");
        applyStimulus(10, 1'b0, 0);
        checkIdle(3, "afterAbortFrame");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
